serial_matrix_driver_multi: RTL and testbench

Parametrised successor to the single-channel serial matrix driver. An SPI-style slave (SCK/SDI/CS) loads a full frame of 24-bit pixels into an internal framebuffer. On a valid frame commit, the block drives NUM_CH WS2812-style single-wire DIN outputs in parallel, with cycle-programmable bit timing. LED1 reports busy and LED2 reports a sticky frame error; both go to the top-level status pins.

---
 rtl/serial_matrix_driver_multi.sv | 224 ++++++++++++++++++++++
 tb/tb_serial_matrix_driver_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_matrix_driver_multi.sv
// SPI-loaded framebuffer driving NUM_CH parallel WS2812-style DIN lines.
// A clean CS window of exactly one full frame commits and starts transmission.
module serial_matrix_driver_multi #(
    parameter int NUM_CH     = 2,
    parameter int NUM_PIXELS = 4,
    parameter int T0H        = 20,
    parameter int T1H        = 40,
    parameter int TBIT       = 62,
    parameter int TRESET     = 2500
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCK,
    input  logic              SDI,
    input  logic              CS,
    output logic [NUM_CH-1:0] DIN,
    output logic              LED1,
    output logic              LED2,
    output logic              FRAME_DONE
);

    localparam int FRAME_BYTES = NUM_CH * NUM_PIXELS * 3;
    localparam int BC_W   = $clog2(FRAME_BYTES + 1);
    localparam int FB_AW  = $clog2(FRAME_BYTES);
    localparam int TCNT_W = $clog2(TBIT);
    localparam int PIX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int LAT_W  = (TRESET > 1) ? $clog2(TRESET) : 1;

    localparam logic [BC_W-1:0]   FRAME_BYTES_C = BC_W'(FRAME_BYTES);
    localparam logic [TCNT_W-1:0] TBIT_LAST     = TCNT_W'(TBIT - 1);
    localparam logic [TCNT_W-1:0] T0H_C         = TCNT_W'(T0H);
    localparam logic [TCNT_W-1:0] T1H_C         = TCNT_W'(T1H);
    localparam logic [PIX_W-1:0]  PIX_LAST      = PIX_W'(NUM_PIXELS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST      = LAT_W'(TRESET - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BIT,
        LATCH
    } state_t;

    state_t state;

    logic sck_p0, sck_p1, sck_p2;
    logic sdi_p0, sdi_p1;
    logic cs_p0, cs_p1, cs_p2;

    logic [2:0]        bit_cnt;
    logic [BC_W-1:0]   byte_cnt;
    logic [6:0]        rx_byte;
    logic              window_bad;
    logic              got_bits;
    logic [7:0]        fb [FRAME_BYTES];

    logic [23:0]       shreg [NUM_CH];
    logic [PIX_W-1:0]  pix_idx;
    logic [4:0]        bit_idx;
    logic [TCNT_W-1:0] tcnt;
    logic [LAT_W-1:0]  lcnt;

    logic sck_rise, cs_fall, cs_rise, cs_active;
    logic commit_ok, commit_bad;

    function automatic logic [BC_W-1:0] sat_inc(input logic [BC_W-1:0] v);
        return (v >= FRAME_BYTES_C) ? FRAME_BYTES_C : v + BC_W'(1);
    endfunction

    function automatic logic [TCNT_W-1:0] hi_len(input logic b);
        return b ? T1H_C : T0H_C;
    endfunction

    function automatic logic [FB_AW-1:0] fb_addr(input int c, input logic [PIX_W-1:0] p, input int k);
        return FB_AW'(c * NUM_PIXELS * 3 + int'(p) * 3 + k);
    endfunction

    // p0/p1: two-flop synchronisers; p2: previous value for edge detection
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sck_p0 <= 1'b0;
            sck_p1 <= 1'b0;
            sck_p2 <= 1'b0;
            sdi_p0 <= 1'b0;
            sdi_p1 <= 1'b0;
            cs_p0  <= 1'b1;
            cs_p1  <= 1'b1;
            cs_p2  <= 1'b1;
        end else begin
            sck_p0 <= SCK;
            sck_p1 <= sck_p0;
            sck_p2 <= sck_p1;
            sdi_p0 <= SDI;
            sdi_p1 <= sdi_p0;
            cs_p0  <= CS;
            cs_p1  <= cs_p0;
            cs_p2  <= cs_p1;
        end
    end

    assign sck_rise  = sck_p1 & ~sck_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;
    assign cs_active = ~cs_p1;

    assign commit_ok  = cs_rise && got_bits && !window_bad && (byte_cnt == FRAME_BYTES_C)
                        && (bit_cnt == 3'd0) && (state == IDLE);
    assign commit_bad = cs_rise && got_bits && !commit_ok;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            window_bad <= 1'b0;
            got_bits   <= 1'b0;
            pix_idx    <= '0;
            bit_idx    <= '0;
            tcnt       <= '0;
            lcnt       <= '0;
            DIN        <= '0;
            LED1       <= 1'b0;
            LED2       <= 1'b0;
            FRAME_DONE <= 1'b0;
            for (int i = 0; i < FRAME_BYTES; i++) begin
                fb[i] <= '0;
            end
        end else begin
            FRAME_DONE <= 1'b0;

            if (cs_fall) begin
                bit_cnt    <= '0;
                byte_cnt   <= '0;
                window_bad <= 1'b0;
                got_bits   <= 1'b0;
            end else if (sck_rise && cs_active) begin
                rx_byte  <= {rx_byte[5:0], sdi_p1};
                bit_cnt  <= bit_cnt + 3'd1;
                got_bits <= 1'b1;
                if (bit_cnt == 3'd7) begin
                    // Bytes are only accepted while the transmitter is idle
                    if (state == IDLE && byte_cnt < FRAME_BYTES_C) begin
                        fb[FB_AW'(byte_cnt)] <= {rx_byte, sdi_p1};
                        byte_cnt             <= sat_inc(byte_cnt);
                    end else begin
                        window_bad <= 1'b1;
                    end
                end
            end

            if (commit_ok) begin
                LED2 <= 1'b0;
            end else if (commit_bad) begin
                LED2 <= 1'b1;
            end

            case (state)
                IDLE: begin
                    DIN <= '0;
                    if (commit_ok) begin
                        state   <= LOAD;
                        LED1    <= 1'b1;
                        pix_idx <= '0;
                    end
                end

                LOAD: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        shreg[c] <= {fb[fb_addr(c, pix_idx, 0)],
                                     fb[fb_addr(c, pix_idx, 1)],
                                     fb[fb_addr(c, pix_idx, 2)]};
                        DIN[c]   <= TCNT_W'(0) < hi_len(fb[fb_addr(c, pix_idx, 0)][7]);
                    end
                    bit_idx <= '0;
                    tcnt    <= '0;
                    state   <= BIT;
                end

                BIT: begin
                    if (tcnt == TBIT_LAST) begin
                        tcnt    <= '0;
                        bit_idx <= bit_idx + 5'd1;
                        for (int c = 0; c < NUM_CH; c++) begin
                            shreg[c] <= {shreg[c][22:0], 1'b0};
                        end
                        if (bit_idx == 5'd23) begin
                            DIN <= '0;
                            if (pix_idx == PIX_LAST) begin
                                state <= LATCH;
                                lcnt  <= '0;
                            end else begin
                                pix_idx <= pix_idx + PIX_W'(1);
                                state   <= LOAD;
                            end
                        end else begin
                            // DIN is registered, so it is set up from the bit about to start
                            for (int c = 0; c < NUM_CH; c++) begin
                                DIN[c] <= TCNT_W'(0) < hi_len(shreg[c][22]);
                            end
                        end
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                        for (int c = 0; c < NUM_CH; c++) begin
                            DIN[c] <= (tcnt + TCNT_W'(1)) < hi_len(shreg[c][23]);
                        end
                    end
                end

                LATCH: begin
                    DIN <= '0;
                    if (lcnt == LAT_LAST) begin
                        state      <= IDLE;
                        LED1       <= 1'b0;
                        FRAME_DONE <= 1'b1;
                    end else begin
                        lcnt <= lcnt + LAT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_matrix_driver_multi.sv
// Bench for serial_matrix_driver_multi: random SPI frames checked against an
// arithmetic timing model of the expected DIN / LED / FRAME_DONE waveforms.
module tb_serial_matrix_driver_multi;

    localparam int NCH     = 2;
    localparam int NPIX    = 4;
    localparam int T0H     = 20;
    localparam int T1H     = 40;
    localparam int TBIT    = 62;
    localparam int TRESET  = 2500;
    localparam int FB      = NCH * NPIX * 3;
    localparam int PIX_CYC = 1 + 24 * TBIT;
    localparam int ACT     = NPIX * PIX_CYC;
    localparam int FD_T    = ACT + TRESET;

    logic           clk = 1'b0;
    logic           rst;
    logic           sck;
    logic           sdi;
    logic           cs;
    logic [NCH-1:0] din;
    logic           led1;
    logic           led2;
    logic           frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tx_buf [32];
    logic [7:0] fbm [FB];
    int         hi0 [24];
    int         hi1 [24];

    serial_matrix_driver_multi #(
        .NUM_CH(NCH), .NUM_PIXELS(NPIX), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dut (
        .CLK(clk), .RESET(rst), .SCK(sck), .SDI(sdi), .CS(cs),
        .DIN(din), .LED1(led1), .LED2(led2), .FRAME_DONE(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic spi_window(input int n);
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                sdi = tx_buf[i][b];
                repeat (4) @(negedge clk);
                sck = 1'b1;
                repeat (4) @(negedge clk);
                sck = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        cs = 1'b1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) tx_buf[i] = 8'($urandom);
    endtask

    task automatic model_write(input int n);
        for (int i = 0; i < n && i < FB; i++) fbm[i] = tx_buf[i];
    endtask

    // Compare every cycle from the first busy cycle to one past FRAME_DONE
    task automatic frame_check(input string tag);
        int lat, p, r, b, tc, din_bad, led_bad, fd_bad, first_bad;
        logic [NCH-1:0] ed;
        logic [23:0]    w;
        logic           eled, efd;
        lat = 0; din_bad = 0; led_bad = 0; fd_bad = 0; first_bad = -1;
        while (led1 !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_start"}, {31'd0, led1 === 1'b1}, 1);
        if (led1 !== 1'b1) return;
        chk({tag, "_lat_ok"}, {31'd0, (lat >= 2 && lat <= 5)}, 1);
        for (int i = 0; i < 24; i++) begin
            hi0[i] = 0;
            hi1[i] = 0;
        end
        for (int t = 0; t <= FD_T + 1; t++) begin
            ed   = '0;
            eled = (t < FD_T);
            efd  = (t == FD_T);
            if (t < ACT) begin
                p = t / PIX_CYC;
                r = t % PIX_CYC;
                if (r != 0) begin
                    b  = (r - 1) / TBIT;
                    tc = (r - 1) % TBIT;
                    for (int c = 0; c < NCH; c++) begin
                        w = {fbm[c*NPIX*3 + p*3], fbm[c*NPIX*3 + p*3 + 1], fbm[c*NPIX*3 + p*3 + 2]};
                        ed[c] = tc < (w[23-b] ? T1H : T0H);
                    end
                    if (p == 0) begin
                        hi0[b] += int'(din[0]);
                        hi1[b] += int'(din[1]);
                    end
                end
            end
            if (din !== ed) begin
                din_bad++;
                if (first_bad < 0) first_bad = t;
            end
            if (led1 !== eled) led_bad++;
            if (frame_done !== efd) fd_bad++;
            @(negedge clk);
        end
        chk({tag, "_din_wave"}, din_bad, 0);
        if (first_bad >= 0) $display("  first DIN difference at offset %0d", first_bad);
        chk({tag, "_led1_wave"}, led_bad, 0);
        chk({tag, "_frame_done"}, fd_bad, 0);
    endtask

    task automatic quiet_watch(input string tag, input int cycles);
        int act;
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (din !== '0 || led1 !== 1'b0 || frame_done !== 1'b0) act++;
        end
        chk({tag, "_quiet"}, act, 0);
    endtask

    initial begin
        int lat, fd_cnt, act;
        rst = 1'b1; sck = 1'b0; sdi = 1'b0; cs = 1'b1;
        for (int i = 0; i < FB; i++) fbm[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_din", {30'd0, din}, 0);
        chk("rst_led1", {31'd0, led1}, 0);
        chk("rst_led2", {31'd0, led2}, 0);
        chk("rst_fd", {31'd0, frame_done}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Fixed frame: ch0 pixel0 = 80 00 01, rest zero
        for (int i = 0; i < 32; i++) tx_buf[i] = 8'h00;
        tx_buf[0] = 8'h80;
        tx_buf[2] = 8'h01;
        model_write(24);
        spi_window(24);
        frame_check("fixed");
        chk("ch0_bit0_hi", hi0[0], 40);
        chk("ch0_bit1_hi", hi0[1], 20);
        chk("ch0_bit23_hi", hi0[23], 40);
        chk("ch1_bit0_hi", hi1[0], 20);
        chk("fixed_led2", {31'd0, led2}, 0);

        // Short frame: partial write, rejected commit
        fill_random();
        model_write(23);
        spi_window(23);
        quiet_watch("short", 20);
        chk("short_led2", {31'd0, led2}, 1);

        fill_random();
        model_write(24);
        spi_window(24);
        frame_check("after_short");
        chk("after_short_led2", {31'd0, led2}, 0);

        // Overlong frame: 24 bytes land, 25th dropped, no start
        fill_random();
        model_write(24);
        spi_window(25);
        quiet_watch("long", 20);
        chk("long_led2", {31'd0, led2}, 1);

        // Empty CS window leaves the error flag alone
        spi_window(0);
        quiet_watch("empty", 10);
        chk("empty_led2", {31'd0, led2}, 1);

        // Write while busy must not disturb the running frame
        fill_random();
        model_write(24);
        spi_window(24);
        fork
            frame_check("busy");
            begin
                repeat (300) @(negedge clk);
                fill_random();
                spi_window(24);
            end
        join
        chk("busy_led2", {31'd0, led2}, 1);
        quiet_watch("busy_after", 10);

        // Mid-frame reset during pixel 2
        fill_random();
        model_write(24);
        spi_window(24);
        lat = 0;
        while (led1 !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("mid_start", {31'd0, led1}, 1);
        repeat (2 * PIX_CYC + 500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_din", {30'd0, din}, 0);
        chk("mid_led1", {31'd0, led1}, 0);
        chk("mid_led2", {31'd0, led2}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < FB; i++) fbm[i] = '0;
        fd_cnt = 0;
        act = 0;
        for (int i = 0; i < FD_T + 100; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_cnt++;
            if (din !== '0 || led1 !== 1'b0) act++;
        end
        chk("mid_no_fd", fd_cnt, 0);
        chk("mid_no_act", act, 0);

        // Recovery with a fresh random frame
        fill_random();
        model_write(24);
        spi_window(24);
        frame_check("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
